// File: rtl/srv1_mem_pkg.sv
// Shared types and helpers for the SRV1 memory port arbiter.
package srv1_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUS_IF   = 2'd1,
        ST_BUS_LS   = 2'd2,
        ST_LS_FAULT = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_t;

    function automatic mem_size_t fn3_size(input logic [1:0] fn3_lo);
        case (fn3_lo)
            2'd0:    fn3_size = SZ_B;
            2'd1:    fn3_size = SZ_H;
            default: fn3_size = SZ_W;
        endcase
    endfunction

    function automatic logic misaligned(input mem_size_t sz, input logic [1:0] addr_low);
        case (sz)
            SZ_H:    misaligned = addr_low[0];
            SZ_W:    misaligned = |addr_low;
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_adj.sv
// Big-endian lane steering: byte enables and replicated/swapped store data
// from funct3, the low address bits and the LS-justified store value.
module store_lane_adj
    import srv1_mem_pkg::*;
(
    input  logic [2:0]  fn3,
    input  logic [1:0]  addr_low,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane
);

    mem_size_t w_size;
    logic      w_unused;

    // Signedness (fn3[2]) only matters to the writeback stage.
    assign w_unused = fn3[2];
    assign w_size   = fn3_size(fn3[1:0]);

    always_comb begin
        be   = 4'b1111;
        lane = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
        case (w_size)
            SZ_B: begin
                be   = 4'b1000 >> addr_low;
                lane = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be   = addr_low[1] ? 4'b0011 : 4'b1100;
                lane = {2{wdata[7:0], wdata[15:8]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one big-endian memory port between instruction fetch and load/store,
// one registered bus transaction at a time, with misalignment and timeout faults.
module mem_port_arbiter
    import srv1_mem_pkg::*;
#(
    parameter int DATA_BURST_MAX = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_fault,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_fn3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int BW = $clog2(DATA_BURST_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(DATA_BURST_MAX);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    arb_state_t    r_state, w_state_nxt;
    logic [BW-1:0] r_burst, w_burst_nxt;
    logic [TW-1:0] r_tmo, w_tmo_nxt;

    logic        r_mem_req, w_mem_req_nxt;
    logic        r_mem_we, w_mem_we_nxt;
    logic [29:0] r_mem_addr, w_mem_addr_nxt;
    logic [3:0]  r_mem_be, w_mem_be_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic        r_if_done, w_if_done_nxt;
    logic        r_if_fault, w_if_fault_nxt;
    logic [31:0] r_if_rdata, w_if_rdata_nxt;
    logic        r_ls_done, w_ls_done_nxt;
    logic        r_ls_fault, w_ls_fault_nxt;
    logic [31:0] r_ls_rdata, w_ls_rdata_nxt;

    logic [3:0]  w_lane_be;
    logic [31:0] w_lane_data;
    logic        w_ls_win;
    logic        w_ls_mis;

    store_lane_adj u_lane (
        .fn3      (ls_fn3),
        .addr_low (ls_addr[1:0]),
        .wdata    (ls_wdata),
        .be       (w_lane_be),
        .lane     (w_lane_data)
    );

    assign w_ls_win = ls_req && (!if_req || (r_burst < BURST_MAX));
    assign w_ls_mis = misaligned(fn3_size(ls_fn3[1:0]), ls_addr[1:0]);

    always_comb begin
        w_state_nxt     = r_state;
        w_burst_nxt     = r_burst;
        w_tmo_nxt       = r_tmo;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_be_nxt    = r_mem_be;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_done_nxt   = 1'b0;
        w_if_fault_nxt  = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_ls_done_nxt   = 1'b0;
        w_ls_fault_nxt  = 1'b0;
        w_ls_rdata_nxt  = r_ls_rdata;

        case (r_state)
            ST_IDLE: begin
                if (w_ls_win) begin
                    w_tmo_nxt = '0;
                    if (if_req) w_burst_nxt = r_burst + 1'b1;
                    if (w_ls_mis) begin
                        w_state_nxt    = ST_LS_FAULT;
                        w_ls_done_nxt  = 1'b1;
                        w_ls_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = ST_BUS_LS;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = ls_we;
                        w_mem_addr_nxt  = ls_addr[31:2];
                        w_mem_be_nxt    = w_lane_be;
                        w_mem_wdata_nxt = ls_we ? w_lane_data : 32'h0;
                    end
                end else if (if_req) begin
                    w_state_nxt     = ST_BUS_IF;
                    w_burst_nxt     = '0;
                    w_tmo_nxt       = '0;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = if_addr;
                    w_mem_be_nxt    = 4'b1111;
                    w_mem_wdata_nxt = 32'h0;
                end
            end
            ST_BUS_IF, ST_BUS_LS: begin
                // An ack in the expiry cycle still wins over the timeout.
                if (mem_ack || (r_tmo == TMO_LAST)) begin
                    w_state_nxt     = ST_IDLE;
                    w_mem_req_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = '0;
                    w_mem_be_nxt    = '0;
                    w_mem_wdata_nxt = '0;
                    if (r_state == ST_BUS_IF) begin
                        w_if_done_nxt  = 1'b1;
                        w_if_fault_nxt = !mem_ack;
                        if (mem_ack) w_if_rdata_nxt = mem_rdata;
                    end else begin
                        w_ls_done_nxt  = 1'b1;
                        w_ls_fault_nxt = !mem_ack;
                        if (mem_ack) w_ls_rdata_nxt = mem_rdata;
                    end
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            ST_LS_FAULT: w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase

        if (!if_req) w_burst_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_burst     <= '0;
            r_tmo       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_if_done   <= 1'b0;
            r_if_fault  <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_done   <= 1'b0;
            r_ls_fault  <= 1'b0;
            r_ls_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst     <= w_burst_nxt;
            r_tmo       <= w_tmo_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_done   <= w_if_done_nxt;
            r_if_fault  <= w_if_fault_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_ls_done   <= w_ls_done_nxt;
            r_ls_fault  <= w_ls_fault_nxt;
            r_ls_rdata  <= w_ls_rdata_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign if_done   = r_if_done;
    assign if_fault  = r_if_fault;
    assign if_rdata  = r_if_rdata;
    assign ls_done   = r_ls_done;
    assign ls_fault  = r_ls_fault;
    assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for lane/alignment cases
// plus hand sequences for timing, burst fairness, timeout and reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [29:0] if_addr = '0;
    logic        if_done, if_fault;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [2:0]  ls_fn3 = '0;
    logic [31:0] ls_addr = '0, ls_wdata = '0;
    logic        ls_done, ls_fault;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_BURST_MAX(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_fault(if_fault),
        .ls_req(ls_req), .ls_we(ls_we), .ls_fn3(ls_fn3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  fn3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] lane;
        logic        mis;
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] rd;
        rd = 32'hC0DE0000 + idx;
        ls_req = 1'b1; ls_we = v.we; ls_fn3 = v.fn3; ls_addr = v.addr; ls_wdata = v.wdata;
        @(negedge clk);
        if (v.mis) begin
            chk($sformatf("v%0d_mis_done", idx), ls_done, 1);
            chk($sformatf("v%0d_mis_fault", idx), ls_fault, 1);
            chk($sformatf("v%0d_mis_memreq", idx), mem_req, 0);
            ls_req = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_mis_done_end", idx), ls_done, 0);
            chk($sformatf("v%0d_mis_memreq2", idx), mem_req, 0);
        end else begin
            chk($sformatf("v%0d_req", idx), mem_req, 1);
            chk($sformatf("v%0d_we", idx), mem_we, v.we);
            chk($sformatf("v%0d_addr", idx), mem_addr, v.addr[31:2]);
            chk($sformatf("v%0d_be", idx), mem_be, v.be);
            if (v.we) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.lane);
            chk($sformatf("v%0d_early_done", idx), ls_done, 0);
            @(negedge clk);
            chk($sformatf("v%0d_req_held", idx), mem_req, 1);
            chk($sformatf("v%0d_be_held", idx), mem_be, v.be);
            mem_ack = 1'b1; mem_rdata = rd;
            @(negedge clk);
            mem_ack = 1'b0;
            chk($sformatf("v%0d_done", idx), ls_done, 1);
            chk($sformatf("v%0d_fault", idx), ls_fault, 0);
            chk($sformatf("v%0d_rdata", idx), ls_rdata, rd);
            chk($sformatf("v%0d_req_drop", idx), mem_req, 0);
            chk($sformatf("v%0d_if_done", idx), if_done, 0);
            ls_req = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", idx), ls_done, 0);
            chk($sformatf("v%0d_rdata_hold", idx), ls_rdata, rd);
        end
    endtask

    task automatic run_fetch(input string tag, input logic [29:0] a, input logic [31:0] rd);
        if_req = 1'b1; if_addr = a;
        @(negedge clk);
        chk({tag, "_req"}, mem_req, 1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_be"}, mem_be, 4'b1111);
        chk({tag, "_we"}, mem_we, 0);
        @(negedge clk);
        chk({tag, "_req_held"}, mem_req, 1);
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0;
        chk({tag, "_done"}, if_done, 1);
        chk({tag, "_fault"}, if_fault, 0);
        chk({tag, "_rdata"}, if_rdata, rd);
        chk({tag, "_ls_done"}, ls_done, 0);
        if_req = 1'b0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, if_done, 0);
        chk({tag, "_rdata_hold"}, if_rdata, rd);
    endtask

    initial begin
        int cnt;
        logic got;
        logic overlap;
        int ngrant;
        logic prev_req;
        logic [1:0] order[6];
        logic [1:0] exp_order[6];

        //           we    fn3   addr          wdata         be       lane          mis
        vecs[0]  = '{1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 4'b0001, 32'hA5A5A5A5, 1'b0};
        vecs[1]  = '{1'b1, 3'd1, 32'h0000_2002, 32'h0000_1234, 4'b0011, 32'h34123412, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 32'h0000_3000, 32'h1122_3344, 4'b1111, 32'h44332211, 1'b0};
        vecs[3]  = '{1'b1, 3'd0, 32'h0000_0040, 32'hFFFF_FF5A, 4'b1000, 32'h5A5A5A5A, 1'b0};
        vecs[4]  = '{1'b1, 3'd1, 32'h0000_0044, 32'h0000_BEEF, 4'b1100, 32'hEFBEEFBE, 1'b0};
        vecs[5]  = '{1'b1, 3'd0, 32'h0000_0006, 32'h0000_00C3, 4'b0010, 32'hC3C3C3C3, 1'b0};
        vecs[6]  = '{1'b0, 3'd2, 32'h0000_0008, 32'h0000_0000, 4'b1111, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 3'd4, 32'h0000_0007, 32'h0000_0000, 4'b0001, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 3'd1, 32'h0000_0001, 32'h0000_0000, 4'b0000, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 3'd2, 32'h0000_0002, 32'h0000_0000, 4'b0000, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 3'd3, 32'h0000_0103, 32'h0000_0000, 4'b0000, 32'h0,        1'b1};

        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_ls_done", ls_done, 0);
        chk("rst_rdata", if_rdata | ls_rdata, 0);
        chk("rst_be", mem_be, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_fetch("fetch", 30'h10, 32'hDEADBEEF);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // spurious ack with no transaction in flight
        mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_done", {30'h0, if_done, ls_done}, 0);
        chk("stray_ack_rdata", ls_rdata, 32'hC0DE0007);

        // requester drops request mid-transaction
        if_req = 1'b1; if_addr = 30'h55;
        @(negedge clk);
        chk("drop_req", mem_req, 1);
        if_req = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("drop_done", if_done, 1);
        chk("drop_rdata", if_rdata, 32'h12345678);
        @(negedge clk);

        // timeout with no ack
        ls_req = 1'b1; ls_we = 1'b0; ls_fn3 = 3'd2; ls_addr = 32'h20;
        cnt = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (mem_req) cnt++;
            if (ls_done) begin
                got = 1'b1;
                chk("tmo_fault", ls_fault, 1);
                chk("tmo_rdata_hold", ls_rdata, 32'hC0DE0007);
                ls_req = 1'b0;
            end
        end
        chk("tmo_done_seen", got, 1);
        chk("tmo_req_cycles", cnt, 8);
        @(negedge clk);
        chk("tmo_pulse", ls_done, 0);

        // ack in the expiry cycle counts as success
        ls_req = 1'b1;
        for (int c = 0; c < 8; c++) @(negedge clk);
        chk("tmo_edge_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'hA0A0A0A0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("tmo_edge_done", ls_done, 1);
        chk("tmo_edge_fault", ls_fault, 0);
        chk("tmo_edge_rdata", ls_rdata, 32'hA0A0A0A0);
        ls_req = 1'b0;
        @(negedge clk);

        // both requesting continuously: burst fairness
        exp_order = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
        order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        if_req = 1'b1; if_addr = 30'h20;
        ls_req = 1'b1; ls_we = 1'b0; ls_fn3 = 3'd2; ls_addr = 32'h100;
        ngrant = 0; prev_req = 1'b0; overlap = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (if_done && ls_done) overlap = 1'b1;
            if (mem_req && !prev_req && ngrant < 6) begin
                order[ngrant] = (mem_addr == 30'h40) ? 2'd1 : (mem_addr == 30'h20) ? 2'd2 : 2'd3;
                ngrant++;
            end
            prev_req = mem_req;
            mem_ack = mem_req;
        end
        if_req = 1'b0; ls_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if_done && ls_done) overlap = 1'b1;
            mem_ack = mem_req;
        end
        mem_ack = 1'b0;
        for (int i = 0; i < 6; i++) chk($sformatf("burst_grant%0d", i), order[i], exp_order[i]);
        chk("burst_no_overlap", overlap, 0);

        // asynchronous reset in the middle of an LS bus cycle
        ls_req = 1'b1; ls_we = 1'b1; ls_fn3 = 3'd2; ls_addr = 32'h40; ls_wdata = 32'h99;
        @(negedge clk);
        chk("rst_mid_req_before", mem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_be", mem_be, 0);
        chk("rst_mid_rdata", ls_rdata, 0);
        @(negedge clk);
        rst = 1'b0; ls_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", mem_req, 0);
        run_fetch("post_rst", 30'h3FF, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
